// File: rtl/mole_pkg.sv
// Shared definitions for the mole game: FSM states, LFSR constants and the
// default hole count used by the pattern generator, controller and keypad.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK          = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED       = 16'hACE1;
  localparam logic [3:0]  NO_PREV            = 4'hF;
  localparam int          DEFAULT_HOLE_COUNT = 9;

  // One Galois step: shift right, fold the mask back in when a 1 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/mole_pattern_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR with seed load; a zero seed would lock the
// register at zero forever, so it is replaced by the default seed.
module lfsr16
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed_in,
  output logic [3:0]  nibble
);

  localparam logic [15:0] SAFE_SEED = (SEED == 16'h0) ? DEFAULT_SEED : SEED;

  logic [15:0] state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SAFE_SEED;
    end else if (load) begin
      state <= (seed_in == 16'h0) ? SAFE_SEED : seed_in;
    end else begin
      state <= lfsr_step(state);
    end
  end

  assign nibble = state[3:0];

endmodule

// File: rtl/mole_pattern_gen.sv
// Builds NIBBLES-position answer patterns from the LFSR by rejection sampling
// and hands each finished pattern to the game controller with a write strobe.
module mole_pattern_gen
  import mole_pkg::*;
#(
  parameter int          NIBBLES    = 8,
  parameter int          HOLE_COUNT = DEFAULT_HOLE_COUNT,
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  parameter int          MAX_REJECT = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_start,
  input  logic                   request,
  input  logic                   seed_load,
  input  logic [15:0]            seed_in,
  output logic [4*NIBBLES-1:0]   data_out,
  output logic                   write_enable,
  output logic                   busy,
  output logic [7:0]             pattern_count
);

  localparam int DATA_W = 4 * NIBBLES;
  localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int REJ_W  = (MAX_REJECT > 0) ? $clog2(MAX_REJECT + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NIBBLES - 1);
  localparam logic [REJ_W-1:0] REJ_LIMIT  = REJ_W'(MAX_REJECT);
  localparam logic [4:0]       HOLE_LIMIT = 5'(HOLE_COUNT);
  localparam logic [3:0]       LAST_POS   = 4'(HOLE_COUNT - 1);

  // Forced position after too many rejections: the hole after prev, wrapping,
  // which can never equal prev because there are at least two holes.
  function automatic logic [3:0] fallback_pos(input logic [3:0] p);
    if (p == NO_PREV || p >= LAST_POS) return 4'd0;
    return p + 4'd1;
  endfunction

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic [REJ_W-1:0]  rej;
  logic              pending;
  logic [3:0]        prev;

  logic [3:0]        cand_raw;
  logic [3:0]        cand;
  logic              natural_ok;
  logic              accept;
  logic              req_any;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (seed_load),
    .seed_in (seed_in),
    .nibble  (cand_raw)
  );

  always_comb begin
    req_any    = game_start | request;
    natural_ok = ({1'b0, cand_raw} < HOLE_LIMIT) && (cand_raw != prev);
    accept     = natural_ok || (rej == REJ_LIMIT);
    cand       = natural_ok ? cand_raw : fallback_pos(prev);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      idx           <= '0;
      rej           <= '0;
      pending       <= 1'b0;
      prev          <= NO_PREV;
      data_out      <= '0;
      write_enable  <= 1'b0;
      pattern_count <= 8'd0;
    end else begin
      write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any || pending) begin
            pending <= 1'b0;
            idx     <= '0;
            rej     <= '0;
            state   <= FILL;
          end
        end

        FILL: begin
          // One request may queue behind the pattern being built.
          if (req_any) pending <= 1'b1;
          if (accept) begin
            acc[{idx, 2'b00} +: 4] <= cand;
            prev                   <= cand;
            rej                    <= '0;
            idx                    <= idx + IDX_W'(1);
            if (idx == LAST_IDX) state <= EMIT;
          end else begin
            rej <= rej + REJ_W'(1);
          end
        end

        EMIT: begin
          if (req_any) pending <= 1'b1;
          data_out     <= acc;
          write_enable <= 1'b1;
          if (pattern_count != 8'hFF) pattern_count <= pattern_count + 8'd1;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mole_pattern_gen.sv
// Directed bench for mole_pattern_gen: default instance plus a two-hole instance.
module tb_mole_pattern_gen;

  logic        clk = 1'b0;
  logic        reset, game_start, request, seed_load;
  logic [15:0] seed_in;
  logic [31:0] data_out;
  logic        write_enable, busy;
  logic [7:0]  pattern_count;
  logic        game_start2, request2;
  logic [31:0] data_out2;
  logic        we2, busy2;
  logic [7:0]  count2;

  int checks = 0;
  int errors = 0;

  logic [15:0] mirror;
  logic [3:0]  prev1, prev2;

  always #5 clk = ~clk;

  mole_pattern_gen dut (
    .clk(clk), .reset(reset), .game_start(game_start), .request(request),
    .seed_load(seed_load), .seed_in(seed_in), .data_out(data_out),
    .write_enable(write_enable), .busy(busy), .pattern_count(pattern_count)
  );

  mole_pattern_gen #(.HOLE_COUNT(2)) dut2 (
    .clk(clk), .reset(reset), .game_start(game_start2), .request(request2),
    .seed_load(seed_load), .seed_in(seed_in), .data_out(data_out2),
    .write_enable(we2), .busy(busy2), .pattern_count(count2)
  );

  function automatic logic [15:0] step16(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Reference copy of the LFSR, driven by the same stimulus as the DUT.
  always @(posedge clk) begin
    if (reset) mirror <= 16'hACE1;
    else if (seed_load) mirror <= (seed_in == 16'h0) ? 16'hACE1 : seed_in;
    else mirror <= step16(mirror);
  end

  // Pattern and FILL cycle count produced from LFSR value l0 with previous position p0.
  function automatic void model_fill(input logic [15:0] l0, input logic [3:0] p0, input int hc,
                                     output logic [31:0] pat, output int cyc);
    logic [15:0] l;
    int p, rej, c;
    bit done;
    l = l0; p = int'(p0); pat = '0; cyc = 0;
    for (int i = 0; i < 8; i++) begin
      done = 0; rej = 0;
      while (!done) begin
        c = int'(l[3:0]);
        cyc++;
        if (c < hc && c != p) done = 1;
        else if (rej == 31) begin c = (p == 15) ? 0 : (p + 1) % hc; done = 1; end
        else rej++;
        if (done) begin pat[4*i +: 4] = c[3:0]; p = c; end
        l = step16(l);
      end
    end
  endfunction

  function automatic bit nibbles_ok(input logic [31:0] p, input int hc);
    for (int i = 0; i < 8; i++) begin
      if (int'(p[4*i +: 4]) >= hc) return 0;
      if (i > 0 && p[4*i +: 4] == p[4*i-4 +: 4]) return 0;
    end
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_we(input bit which, input int limit, output int k, output bit ok);
    ok = 0; k = 0;
    while (k < limit && !ok) begin
      tick(); k++;
      if ((which ? we2 : write_enable) === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1; game_start = 0; request = 0; seed_load = 0; seed_in = 16'h0;
    game_start2 = 0; request2 = 0;
    tick(); tick();
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h want %h", data_out, 32'h0); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", write_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (pattern_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pattern_count); end
    checks++; if (dut.u_lfsr.state !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr got %h want ace1", dut.u_lfsr.state); end
    checks++; if (data_out2 !== 32'h0) begin errors++; $display("FAIL reset_data_out2 got %h want 0", data_out2); end
    reset = 0; prev1 = 4'hF; prev2 = 4'hF;
  endtask

  task automatic test_first_pattern();
    logic [31:0] pat;
    int n, k;
    bit ok;
    game_start = 1; tick(); game_start = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", busy); end
    model_fill(mirror, prev1, 9, pat, n);
    wait_we(0, 300, k, ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_timeout got no write_enable want one within 257"); return; end
    checks++; if (k != n + 1) begin errors++; $display("FAIL first_latency got %0d want %0d", k, n + 1); end
    checks++; if (data_out !== pat) begin errors++; $display("FAIL first_data got %h want %h", data_out, pat); end
    checks++; if (!nibbles_ok(data_out, 9)) begin errors++; $display("FAIL first_nibbles got %h want legal non-repeating", data_out); end
    checks++; if (pattern_count !== 8'd1) begin errors++; $display("FAIL first_count got %0d want 1", pattern_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_busy_emit got %b want 0", busy); end
    prev1 = pat[31:28];
    tick();
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL first_we_width got %b want 0", write_enable); end
  endtask

  task automatic test_seed();
    logic [31:0] pat;
    int n, k;
    bit ok;
    seed_in = 16'h0; seed_load = 1; tick(); seed_load = 0;
    checks++; if (dut.u_lfsr.state !== 16'hACE1) begin errors++; $display("FAIL seed_zero got %h want ace1", dut.u_lfsr.state); end
    seed_in = 16'h1234; seed_load = 1; tick(); seed_load = 0;
    checks++; if (dut.u_lfsr.state !== 16'h1234) begin errors++; $display("FAIL seed_load got %h want 1234", dut.u_lfsr.state); end
    seed_in = 16'h0; seed_load = 1; tick(); seed_load = 0;
    game_start = 1; tick(); game_start = 0;
    model_fill(mirror, prev1, 9, pat, n);
    wait_we(0, 300, k, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seed_timeout got no write_enable want one"); return; end
    checks++; if (k != n + 1) begin errors++; $display("FAIL seed_latency got %0d want %0d", k, n + 1); end
    checks++; if (data_out !== pat) begin errors++; $display("FAIL seed_data got %h want %h", data_out, pat); end
    checks++; if (pattern_count !== 8'd2) begin errors++; $display("FAIL seed_count got %0d want 2", pattern_count); end
    prev1 = pat[31:28];
  endtask

  task automatic test_pending();
    logic [31:0] pat1, pat2;
    int n1, n2, k, pulses;
    bit ok;
    game_start = 1; tick(); game_start = 0;
    model_fill(mirror, prev1, 9, pat1, n1);
    tick(); request = 1; tick(); request = 0;
    tick(); tick(); request = 1; game_start = 1; tick(); request = 0; game_start = 0;
    wait_we(0, 300, k, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pend_timeout1 got no write_enable want one"); return; end
    checks++; if (k + 5 != n1 + 1) begin errors++; $display("FAIL pend_latency1 got %0d want %0d", k + 5, n1 + 1); end
    checks++; if (data_out !== pat1) begin errors++; $display("FAIL pend_data1 got %h want %h", data_out, pat1); end
    prev1 = pat1[31:28];
    tick();
    model_fill(mirror, prev1, 9, pat2, n2);
    wait_we(0, 300, k, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pend_timeout2 got no write_enable want one"); return; end
    checks++; if (k != n2 + 1) begin errors++; $display("FAIL pend_latency2 got %0d want %0d", k, n2 + 1); end
    checks++; if (data_out !== pat2) begin errors++; $display("FAIL pend_data2 got %h want %h", data_out, pat2); end
    checks++; if (data_out[3:0] === pat1[31:28]) begin errors++; $display("FAIL pend_boundary got %h want not %h", data_out[3:0], pat1[31:28]); end
    prev1 = pat2[31:28];
    pulses = 0;
    repeat (300) begin tick(); if (write_enable === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL pend_dropped got %0d extra pulses want 0", pulses); end
    checks++; if (pattern_count !== 8'd4) begin errors++; $display("FAIL pend_count got %0d want 4", pattern_count); end
  endtask

  task automatic test_hole2();
    logic [31:0] pat;
    int n, k;
    bit ok;
    for (int r = 0; r < 100; r++) begin
      request2 = 1; tick(); request2 = 0;
      model_fill(mirror, prev2, 2, pat, n);
      wait_we(1, 300, k, ok);
      checks++; if (!ok) begin errors++; $display("FAIL hole2_timeout got no write_enable want one at %0d", r); return; end
      checks++; if (k != n + 1) begin errors++; $display("FAIL hole2_latency got %0d want %0d at %0d", k, n + 1, r); end
      checks++; if (data_out2 !== pat) begin errors++; $display("FAIL hole2_data got %h want %h at %0d", data_out2, pat, r); end
      checks++; if (data_out2 !== 32'h10101010 && data_out2 !== 32'h01010101) begin
        errors++; $display("FAIL hole2_shape got %h want 10101010 or 01010101", data_out2);
      end
      checks++; if (data_out2[3:0] === prev2) begin errors++; $display("FAIL hole2_boundary got %h want not %h", data_out2[3:0], prev2); end
      prev2 = data_out2[31:28];
    end
  endtask

  task automatic test_reset_mid_fill();
    bit found;
    request = 1; tick(); request = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (dut.idx == 4) found = 1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL midfill_reach got idx %0d want 4", dut.idx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midfill_busy got %b want 1", busy); end
    reset = 1; tick();
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL midfill_data got %h want 0", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midfill_busy_after got %b want 0", busy); end
    checks++; if (pattern_count !== 8'd0) begin errors++; $display("FAIL midfill_count got %0d want 0", pattern_count); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL midfill_we got %b want 0", write_enable); end
    reset = 0; prev1 = 4'hF; prev2 = 4'hF;
  endtask

  task automatic test_back_to_back();
    int pulses, cyc, expc;
    bit last;
    pulses = 0; cyc = 0; last = 0;
    request = 1;
    while (pulses < 300 && cyc < 60000) begin
      tick(); cyc++;
      if (write_enable === 1'b1) begin
        pulses++;
        checks++; if (last) begin errors++; $display("FAIL b2b_we_double got 2 consecutive want 1 at pulse %0d", pulses); end
        expc = (pulses > 255) ? 255 : pulses;
        checks++; if (pattern_count !== 8'(expc)) begin errors++; $display("FAIL b2b_count got %0d want %0d", pattern_count, expc); end
        checks++; if (!nibbles_ok(data_out, 9) || data_out[3:0] === prev1) begin
          errors++; $display("FAIL b2b_pattern got %h want legal, nibble0 not %h", data_out, prev1);
        end
        prev1 = data_out[31:28];
      end
      last = write_enable;
    end
    request = 0;
    checks++; if (pulses != 300) begin errors++; $display("FAIL b2b_pulses got %0d want 300", pulses); end
    repeat (300) begin
      tick();
      if (write_enable === 1'b1) begin
        checks++; if (last) begin errors++; $display("FAIL b2b_drain_double got 2 consecutive want 1"); end
      end
      last = write_enable;
    end
    checks++; if (pattern_count !== 8'd255) begin errors++; $display("FAIL b2b_saturate got %0d want 255", pattern_count); end
  endtask

  initial begin
    test_reset();
    test_first_pattern();
    test_seed();
    test_pending();
    test_hole2();
    test_reset_mid_fill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
